// File: rtl/hack_cpu_core.sv
//------------------------------------------------------------------------------
// Module   : hack_cpu_core
// Purpose  : Hack CPU decode/control with A, D, PC registers around the ALU.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hack_alu (
  output logic [15:0] out,
  output logic        zr,
  output logic        ng,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no
);

  logic [15:0] w_x_z;
  logic [15:0] w_x_n;
  logic [15:0] w_y_z;
  logic [15:0] w_y_n;
  logic [15:0] w_fn;

  always_comb begin
    w_x_z = zx ? 16'h0000 : x;
    w_x_n = nx ? ~w_x_z : w_x_z;
    w_y_z = zy ? 16'h0000 : y;
    w_y_n = ny ? ~w_y_z : w_y_z;
    w_fn  = f ? (w_x_n + w_y_n) : (w_x_n & w_y_n);
    out   = no ? ~w_fn : w_fn;
    zr    = (out == 16'h0000);
    ng    = out[15];
  end

endmodule

module hack_cpu_core #(
  parameter int unsigned PC_W     = 15,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic [15:0]     instruction,
  input  logic [15:0]     inM,
  output logic [15:0]     outM,
  output logic            writeM,
  output logic [PC_W-1:0] addressM,
  output logic [PC_W-1:0] pc
);

  localparam logic [PC_W-1:0] c_reset_pc = RESET_PC[PC_W-1:0];
  localparam logic [PC_W-1:0] c_pc_one   = {{(PC_W-1){1'b0}}, 1'b1};

  logic [15:0]     r_a;
  logic [15:0]     r_d;
  logic [PC_W-1:0] r_pc;

  logic            w_is_c;
  logic            w_dest_a;
  logic            w_dest_d;
  logic            w_dest_m;
  logic            w_jump;
  logic [15:0]     w_y;
  logic [15:0]     w_alu_out;
  logic            w_alu_zr;
  logic            w_alu_ng;
  logic            w_unused_bits;

  assign w_is_c   = instruction[15];
  assign w_dest_a = instruction[5];
  assign w_dest_d = instruction[4];
  assign w_dest_m = instruction[3];
  assign w_y      = instruction[12] ? inM : r_a;

  // Opcode bits [14:13] carry no meaning for this core.
  assign w_unused_bits = ^instruction[14:13];

  hack_alu u_alu (
    .out (w_alu_out),
    .zr  (w_alu_zr),
    .ng  (w_alu_ng),
    .x   (r_d),
    .y   (w_y),
    .zx  (instruction[11]),
    .nx  (instruction[10]),
    .zy  (instruction[9]),
    .ny  (instruction[8]),
    .f   (instruction[7]),
    .no  (instruction[6])
  );

  assign w_jump = w_is_c & ((instruction[2] & w_alu_ng) |
                            (instruction[1] & w_alu_zr) |
                            (instruction[0] & ~w_alu_ng & ~w_alu_zr));

  assign outM     = w_alu_out;
  assign writeM   = w_is_c & w_dest_m & ~stall & ~reset;
  assign addressM = r_a[PC_W-1:0];
  assign pc       = r_pc;

  // Jump target uses the pre-writeback A, so "A=...;JMP" branches to the old A.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a  <= 16'h0000;
      r_d  <= 16'h0000;
      r_pc <= c_reset_pc;
    end else if (!stall) begin
      if (!w_is_c) begin
        r_a <= instruction;
      end else begin
        if (w_dest_a) r_a <= w_alu_out;
        if (w_dest_d) r_d <= w_alu_out;
      end
      r_pc <= w_jump ? r_a[PC_W-1:0] : (r_pc + c_pc_one);
    end
  end

endmodule

`default_nettype wire
